// File: rtl/map_scroller_pkg.sv
// Shared types and constants for the overworld map scroller.
//   dir_t          : movement / facing direction (encoding matches the facing output)
//   scroll_state_t : main scroller FSM states
//   KEY_*          : keycodes that request a tile move
package map_scroller_pkg;

    typedef enum logic [1:0] {
        DirUp    = 2'd0,
        DirDown  = 2'd1,
        DirLeft  = 2'd2,
        DirRight = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        StIdle,
        StProbe,
        StMove,
        StLock
    } scroll_state_t;

    localparam logic [7:0] KEY_UP    = 8'h1A;
    localparam logic [7:0] KEY_DOWN  = 8'h16;
    localparam logic [7:0] KEY_LEFT  = 8'h04;
    localparam logic [7:0] KEY_RIGHT = 8'h07;

endpackage

// File: rtl/map_scroller_if.sv
// Collision/palette lookup handshake between the scroller (master) and the lookup (slave).
//   coll_req     : query valid, held until coll_ack
//   coll_x/y     : probe coordinate, stable while coll_req is high
//   coll_ack     : single-cycle answer strobe
//   coll_blocked : qualified by coll_ack; 1 = target tile is impassable
interface map_scroller_if #(
    parameter int unsigned COORD_W = 10
);
    logic               coll_req;
    logic [COORD_W-1:0] coll_x;
    logic [COORD_W-1:0] coll_y;
    logic               coll_ack;
    logic               coll_blocked;

    modport master (
        output coll_req,
        output coll_x,
        output coll_y,
        input  coll_ack,
        input  coll_blocked
    );

    modport slave (
        input  coll_req,
        input  coll_x,
        input  coll_y,
        output coll_ack,
        output coll_blocked
    );
endinterface

// File: rtl/map_scroller_dir_decode.sv
// Combinational WASD keycode decoder.
//   keycode_i : raw keycode
//   valid_o   : keycode is one of the four movement keys
//   dir_o     : decoded direction (DirDown when not valid)
module map_dir_decode
    import map_scroller_pkg::*;
(
    input  logic [7:0] keycode_i,
    output logic       valid_o,
    output dir_t       dir_o
);
    always_comb begin
        valid_o = 1'b1;
        dir_o   = DirDown;
        case (keycode_i)
            KEY_UP:    dir_o = DirUp;
            KEY_DOWN:  dir_o = DirDown;
            KEY_LEFT:  dir_o = DirLeft;
            KEY_RIGHT: dir_o = DirRight;
            default:   valid_o = 1'b0;
        endcase
    end
endmodule

// File: rtl/map_scroller.sv
// Tile-stepped viewport scroller. A movement key turns the camera and, if a whole tile fits
// inside the map, probes the collision lookup; an unblocked answer scrolls one tile at STEP px
// per clock. Battles freeze motion until the battle ends and the key is released.
//   frame_clk, Reset_n : clock, synchronous active-low reset
//   keycode, battle_bit: player input and battle status
//   coll               : collision lookup handshake (master side)
//   FrameX/FrameY      : viewport top-left corner
//   facing, moving     : camera direction, high while scrolling
//   step_done          : pulse when a tile move lands
//   tile_steps         : saturating count of completed tile moves
module map_scroller
    import map_scroller_pkg::*;
#(
    parameter int unsigned COORD_W     = 10,
    parameter int unsigned MAP_W       = 380,
    parameter int unsigned MAP_H       = 406,
    parameter int unsigned VIEW_W      = 240,
    parameter int unsigned VIEW_H      = 160,
    parameter int unsigned TILE        = 16,
    parameter int unsigned STEP        = 1,
    parameter int unsigned START_X     = 0,
    parameter int unsigned START_Y     = 0,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic               frame_clk,
    input  logic               Reset_n,
    input  logic [7:0]         keycode,
    input  logic [1:0]         battle_bit,
    map_scroller_if.master     coll,
    output logic [COORD_W-1:0] FrameX,
    output logic [COORD_W-1:0] FrameY,
    output logic [1:0]         facing,
    output logic               moving,
    output logic               step_done,
    output logic [15:0]        tile_steps
);
    if (TILE % STEP != 0) begin : g_bad_step
        $error("TILE must be a multiple of STEP");
    end
    if (START_X % TILE != 0 || START_Y % TILE != 0) begin : g_bad_start
        $error("START_X/START_Y must be multiples of TILE");
    end

    localparam int unsigned CW1  = COORD_W + 1;
    localparam int unsigned REM_W = $clog2(TILE + 1);
    localparam int unsigned TO_W  = $clog2(ACK_TIMEOUT + 1);

    localparam logic [CW1-1:0]     X_MAX   = CW1'(MAP_W - VIEW_W);
    localparam logic [CW1-1:0]     Y_MAX   = CW1'(MAP_H - VIEW_H);
    localparam logic [CW1-1:0]     TILE_W  = CW1'(TILE);
    localparam logic [COORD_W-1:0] TILE_C  = COORD_W'(TILE);
    localparam logic [COORD_W-1:0] STEP_C  = COORD_W'(STEP);
    localparam logic [COORD_W-1:0] HALF_W  = COORD_W'(VIEW_W / 2);
    localparam logic [COORD_W-1:0] HALF_H  = COORD_W'(VIEW_H / 2);
    localparam logic [TO_W-1:0]    TO_LAST = TO_W'(ACK_TIMEOUT - 1);

    scroll_state_t      state_q, state_d;
    dir_t               facing_q, facing_d;
    logic [COORD_W-1:0] fx_q, fx_d, fy_q, fy_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic [TO_W-1:0]    to_q, to_d;
    logic               step_done_q, step_done_d;
    logic [15:0]        steps_q, steps_d;

    logic key_valid;
    dir_t key_dir;
    logic fits;

    map_dir_decode u_dir_decode (
        .keycode_i (keycode),
        .valid_o   (key_valid),
        .dir_o     (key_dir)
    );

    // Widened compares so Frame+TILE can never wrap before the limit check.
    always_comb begin
        unique case (key_dir)
            DirUp:    fits = {1'b0, fy_q} >= TILE_W;
            DirDown:  fits = ({1'b0, fy_q} + TILE_W) <= Y_MAX;
            DirLeft:  fits = {1'b0, fx_q} >= TILE_W;
            DirRight: fits = ({1'b0, fx_q} + TILE_W) <= X_MAX;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        facing_d    = facing_q;
        fx_d        = fx_q;
        fy_d        = fy_q;
        rem_d       = rem_q;
        to_d        = to_q;
        step_done_d = 1'b0;
        steps_d     = steps_q;
        unique case (state_q)
            StIdle: begin
                if (battle_bit != 2'b00) begin
                    state_d = StLock;
                end else if (key_valid) begin
                    facing_d = key_dir;
                    if (fits) begin
                        state_d = StProbe;
                        to_d    = '0;
                    end
                end
            end
            StProbe: begin
                if (coll.coll_ack) begin
                    state_d = coll.coll_blocked ? StIdle : StMove;
                    rem_d   = REM_W'(TILE);
                end else if (to_q == TO_LAST) begin
                    state_d = StIdle;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            StMove: begin
                unique case (facing_q)
                    DirUp:    fy_d = fy_q - STEP_C;
                    DirDown:  fy_d = fy_q + STEP_C;
                    DirLeft:  fx_d = fx_q - STEP_C;
                    DirRight: fx_d = fx_q + STEP_C;
                endcase
                rem_d = rem_q - REM_W'(STEP);
                if (rem_q == REM_W'(STEP)) begin
                    step_done_d = 1'b1;
                    state_d     = StIdle;
                    if (steps_q != 16'hFFFF) begin
                        steps_d = steps_q + 16'd1;
                    end
                end
            end
            StLock: begin
                // A held key must be released before movement resumes.
                if (battle_bit == 2'b00 && keycode == 8'h00) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge frame_clk) begin
        if (!Reset_n) begin
            state_q     <= StIdle;
            facing_q    <= DirDown;
            fx_q        <= COORD_W'(START_X);
            fy_q        <= COORD_W'(START_Y);
            rem_q       <= '0;
            to_q        <= '0;
            step_done_q <= 1'b0;
            steps_q     <= '0;
        end else begin
            state_q     <= state_d;
            facing_q    <= facing_d;
            fx_q        <= fx_d;
            fy_q        <= fy_d;
            rem_q       <= rem_d;
            to_q        <= to_d;
            step_done_q <= step_done_d;
            steps_q     <= steps_d;
        end
    end

    // Probe the centre of the viewport shifted one tile in the facing direction.
    always_comb begin
        coll.coll_x = fx_q + HALF_W;
        coll.coll_y = fy_q + HALF_H;
        unique case (facing_q)
            DirUp:    coll.coll_y = fy_q + HALF_H - TILE_C;
            DirDown:  coll.coll_y = fy_q + HALF_H + TILE_C;
            DirLeft:  coll.coll_x = fx_q + HALF_W - TILE_C;
            DirRight: coll.coll_x = fx_q + HALF_W + TILE_C;
        endcase
    end

    assign coll.coll_req = (state_q == StProbe);
    assign FrameX        = fx_q;
    assign FrameY        = fy_q;
    assign facing        = facing_q;
    assign moving        = (state_q == StMove);
    assign step_done     = step_done_q;
    assign tile_steps    = steps_q;
endmodule
